// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: FSM encoding, peripheral map, region decode.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: none.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_LED = 2'd1,
    REG_CNT = 2'd2
  } region_t;

  localparam logic [3:0] PERIPH_BASE = 4'hF;
  localparam logic       LED_SEL     = 1'b0;
  localparam logic       CNT_SEL     = 1'b1;

  // The top nibble picks the peripheral window; bit 2 picks the device within it.
  function automatic region_t decode_region(input logic [3:0] top_nibble, input logic sel_bit);
    region_t r;
    r = REG_RAM;
    if (top_nibble == PERIPH_BASE) begin
      r = (sel_bit == CNT_SEL) ? REG_CNT : REG_LED;
    end
    return r;
  endfunction

endpackage

// File: rtl/mio_counter.sv
// 32-bit free-running counter with synchronous load; wraps 32'hFFFFFFFF -> 0.
// Latency: load value visible the cycle after load_en.
// Backpressure: none; load wins over the increment on the same edge.
module mio_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] load_val,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'h0;
    end else if (load_en) begin
      cnt <= load_val;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU memory/IO responder decoding RAM, LED/switch port and counter.
// Latency: MIO_ready and read data WAIT_CYCLES+1 cycles after the request is sampled.
// Backpressure: CPU holds CPU_MIO until MIO_ready; dropping it during ACCESS aborts.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Cpu_data2bus,
  output logic [31:0]       Cpu_data4bus,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  localparam int WAIT_W = 4;

  state_t            state_q, state_d;
  region_t           region;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_mux;
  logic [31:0]       cnt;
  logic [15:0]       led_q;
  logic              latch_rd;
  logic              wr_commit;
  logic              cnt_load;
  logic              unused_addr_bits;

  assign region           = decode_region(addr_bus[31:28], addr_bus[2]);
  assign ram_addr         = addr_bus[RAM_AW+1:2];
  assign ram_din          = Cpu_data2bus;
  assign unused_addr_bits = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only DONE produces the strobe and the write commit, so outputs stay glitch-free.
  always_comb begin
    state_d   = state_q;
    latch_rd  = 1'b0;
    wr_commit = 1'b0;
    MIO_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (CPU_MIO) state_d = ACCESS;
      end
      ACCESS: begin
        if (!CPU_MIO) begin
          state_d = IDLE;
        end else if (wait_q == '0) begin
          latch_rd = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        MIO_ready = 1'b1;
        wr_commit = mem_w;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (state_q == IDLE && CPU_MIO) begin
      wait_q <= WAIT_W'(WAIT_CYCLES - 1);
    end else if (state_q == ACCESS && wait_q != '0) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  always_comb begin
    rd_mux = ram_dout;
    case (region)
      REG_LED: rd_mux = {16'h0, sw};
      REG_CNT: rd_mux = cnt;
      default: rd_mux = ram_dout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (latch_rd) begin
      rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 16'h0;
    end else if (wr_commit && region == REG_LED) begin
      led_q <= Cpu_data2bus[15:0];
    end
  end

  assign cnt_load     = wr_commit && (region == REG_CNT);
  assign ram_we       = wr_commit && (region == REG_RAM);
  assign led          = led_q;
  assign Cpu_data4bus = (MIO_ready && !mem_w) ? rdata_q : 32'h0;

  mio_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (cnt_load),
    .load_val (Cpu_data2bus),
    .cnt      (cnt)
  );

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: directed cases plus randomized traffic.
// Expected responses are queued at issue time and checked by an independent monitor.
module tb_mio_bus_responder;

  localparam int W  = 2;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CPU_MIO = 1'b0;
  logic          mem_w = 1'b0;
  logic [31:0]   addr_bus = '0;
  logic [31:0]   Cpu_data2bus = '0;
  logic [31:0]   Cpu_data4bus;
  logic          MIO_ready;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_we;
  logic [31:0]   ram_dout = '0;
  logic [15:0]   sw = '0;
  logic [15:0]   led;

  always #5 clk = ~clk;

  mio_bus_responder #(.WAIT_CYCLES(W), .RAM_AW(AW)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CPU_MIO      (CPU_MIO),
    .mem_w        (mem_w),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (Cpu_data2bus),
    .Cpu_data4bus (Cpu_data4bus),
    .MIO_ready    (MIO_ready),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_dout     (ram_dout),
    .sw           (sw),
    .led          (led)
  );

  // External synchronous block RAM with one-cycle read latency.
  bit [31:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Edge counter: after rising edge n, cyc == n.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference counter: +1 per edge, replaced by a committed write on its commit edge.
  logic [31:0] m_cnt = '0;
  int unsigned ld_edge = 32'hFFFF_FFFF;
  logic [31:0] ld_val = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 m_cnt <= '0;
    else if (cyc + 1 == ld_edge) m_cnt <= ld_val;
    else                        m_cnt <= m_cnt + 32'd1;
  end

  bit [31:0]   ref_mem [1024];
  logic [15:0] ref_led = '0;

  typedef struct {
    int unsigned rcyc;
    logic [31:0] data;
    bit          we;
    logic [9:0]  widx;
    logic [31:0] din;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cnt_value", u_dut.u_counter.cnt, m_cnt);
      if (MIO_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", {31'h0, MIO_ready}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ready_cycle", cyc, e.rcyc);
          chk("rdata", Cpu_data4bus, e.data);
          chk("done_ram_we", {31'h0, ram_we}, {31'h0, e.we});
          if (e.we) begin
            chk("ram_addr", {22'h0, ram_addr}, {22'h0, e.widx});
            chk("ram_din", ram_din, e.din);
          end
        end
      end else begin
        chk("idle_data", Cpu_data4bus, 32'h0);
        chk("idle_ram_we", {31'h0, ram_we}, 32'h0);
      end
    end
  end

  // Called #1 after a rising edge; request is sampled at the next edge k.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] s, output int unsigned rdy_cyc);
    exp_t        x;
    int unsigned k;
    bit          seen;
    k      = cyc + 1;
    x.rcyc = k + W;
    x.we   = 1'b0;
    x.widx = a[11:2];
    x.din  = d;
    x.data = 32'h0;
    if (a[31:28] == 4'hF) begin
      if (a[2]) begin
        if (w) begin
          ld_edge = k + W + 1;
          ld_val  = d;
        end else begin
          x.data = m_cnt + 32'(W);
        end
      end else begin
        if (w) ref_led = d[15:0];
        else   x.data = {16'h0, s};
      end
    end else begin
      if (w) begin
        ref_mem[a[11:2]] = d;
        x.we = 1'b1;
      end else begin
        x.data = ref_mem[a[11:2]];
      end
    end
    sb.push_back(x);
    sw = s; CPU_MIO = 1'b1; mem_w = w; addr_bus = a; Cpu_data2bus = d;
    seen = 1'b0;
    for (int i = 0; i < W + 6 && !seen; i++) begin
      @(negedge clk);
      if (MIO_ready) seen = 1'b1;
    end
    rdy_cyc = cyc;
    chk("ready_seen", {31'h0, seen}, 32'h1);
    @(posedge clk);
    #1;
    chk("led", {16'h0, led}, {16'h0, ref_led});
  endtask

  task automatic idle(input int n);
    CPU_MIO = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want <100000", $time);
    $fatal(1);
  end

  initial begin
    int unsigned r1, r2, rd;
    int          sel;
    logic [31:0] a;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_cnt", u_dut.u_counter.cnt, 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Reset in the middle of an LED write
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'hF000_0000; Cpu_data2bus = 32'h0000_5555;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    CPU_MIO = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ready", {31'h0, MIO_ready}, 32'h0);
    chk("midrst_state", 32'(u_dut.state_q), 32'h0);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_led", {16'h0, led}, 32'h0);

    // RAM write then read
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0, rd);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, rd);
    idle(1);

    // LED write, switch read
    do_txn(1'b1, 32'hF000_0000, 32'h1234_ABCD, 16'h0, rd);
    chk("led_abcd", {16'h0, led}, 32'h0000_ABCD);
    do_txn(1'b0, 32'hF000_0000, 32'h0, 16'h00F0, rd);
    idle(2);

    // Counter wrap: write FFFFFFFE, back-to-back read lands after the wrap
    do_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 16'h0, rd);
    do_txn(1'b0, 32'hF000_0004, 32'h0, 16'h0, rd);
    idle(3);
    do_txn(1'b0, 32'hF000_0004, 32'h0, 16'h0, rd);
    idle(1);

    // Abort a RAM write mid-ACCESS
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0020; Cpu_data2bus = 32'hCAFE_F00D;
    @(posedge clk); #1;
    CPU_MIO = 1'b0;
    idle(4);
    chk("abort_mem", ram_mem[8], 32'h0);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 16'h0, rd);

    // Back-to-back reads with CPU_MIO held
    do_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, r1);
    do_txn(1'b0, 32'h0000_0014, 32'h0, 16'h0, r2);
    chk("b2b_period", r2 - r1, 32'(W + 2));
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1)
        a = {4'($urandom_range(0, 14)), 16'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
      else if (sel == 2)
        a = {4'hF, 25'($urandom), 1'b0, 2'($urandom)};
      else
        a = {4'hF, 25'($urandom), 1'b1, 2'($urandom)};
      do_txn(1'($urandom), a, $urandom, 16'($urandom), rd);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    idle(5);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder that answers the single-cycle CPU's memory requests (CPU_MIO, mem_w, address, write data) and returns MIO_ready plus read data after a fixed number of wait states. It decodes each access to data RAM (external synchronous block RAM, 1-cycle read latency), a 16-bit LED/switch port or a 32-bit free-running counter. It sits between the CPU core and the memory/peripheral fabric. While a request is pending, the CPU stalls on MIO_ready = 0.

## Interface
- WAIT_CYCLES, 2, number of ACCESS cycles per transaction; legal range 1..15; minimum 1 covers RAM read latency.
- RAM_AW, 10, RAM word-address width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- CPU_MIO  in  1  request valid; held by CPU until it samples MIO_ready = 1.
- mem_w  in  1  1 = write, 0 = read; stable while CPU_MIO = 1.
- addr_bus  in  32  byte address; stable while CPU_MIO = 1.
- Cpu_data2bus  in  32  write data; stable while CPU_MIO = 1.
- Cpu_data4bus  out  32  read data; valid only while MIO_ready = 1.
- MIO_ready  out  1  one-cycle completion strobe.
- ram_addr  out  RAM_AW  RAM word address = addr_bus[RAM_AW+1:2]; combinational.
- ram_din  out  32  = Cpu_data2bus; combinational.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data, valid 1 cycle after ram_addr.
- sw  in  16  switch inputs.
- led  out  16  LED register.

## Operation
- Decode:
  - addr_bus[31:28] = 4'hF selects a peripheral: addr_bus[2] = 0 selects LED/SW, addr_bus[2] = 1 selects the counter.
  - Every other address selects RAM, aliased modulo 2^RAM_AW words.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if CPU_MIO = 1, load wait counter with WAIT_CYCLES-1 and go to ACCESS.
  - ACCESS: count down; at 0, latch read data into rdata_q and go to DONE.
  - DONE: MIO_ready = 1; go to IDLE unconditionally.
- Read data latched at the end of the last ACCESS cycle:
  - RAM: ram_dout.
  - LED/SW: {16'h0, sw}.
  - Counter: current counter value.
- Writes commit only at the clock edge ending DONE:
  - RAM: ram_we = 1 combinationally during DONE when mem_w = 1 and RAM is selected.
  - LED/SW: led <= Cpu_data2bus[15:0].
  - Counter: cnt <= Cpu_data2bus.
- Counter increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0. On a counter write, the write value wins over the increment for that edge.
- Cpu_data4bus = rdata_q during DONE, 32'h0 otherwise; during write transactions it is 0.
- Abort: if CPU_MIO falls during ACCESS, return to IDLE next edge. No ready, no write.
- CPU_MIO still 1 in IDLE after DONE is a new request (back-to-back). Minimum transaction period is WAIT_CYCLES+2 cycles.
- Reset, asynchronous, any state including mid-transaction:
  - state = IDLE, MIO_ready = 0, ram_we = 0, led = 0, cnt = 0, rdata_q = 0.
  - A pending write is dropped.

## Timing
- Request sampled in IDLE at edge k.
- ACCESS occupies cycles k+1 .. k+WAIT_CYCLES.
- MIO_ready is high for exactly cycle k+WAIT_CYCLES+1. The CPU advances at the edge ending that cycle, which is also the write-commit edge.
- Read latency from request to data is WAIT_CYCLES+1 cycles.
- Counter read value is cnt at the last ACCESS edge, i.e. the value sampled at edge k+WAIT_CYCLES.
- MIO_ready, ram_we and Cpu_data4bus are glitch-free: they are decoded from registered state and stable inputs only.

## Structure
- Shared package mio_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - PERIPH_BASE nibble 4'hF;
  - LED_SEL / CNT_SEL select values;
  - the region enum (REG_RAM, REG_LED, REG_CNT).
- One sub-module, mio_counter, implements the 32-bit free-running counter with synchronous load (inputs load_en, load_val; output cnt). It is reusable as a timer elsewhere.
- Decode and FSM stay in mio_bus_responder.

## Test plan
- Reset then idle: rst_n low for 3 cycles, released -> MIO_ready = 0, led = 0, cnt = 0 and counting 0, 1, 2, ....
- RAM write/read, WAIT_CYCLES = 2:
  - Write 0xDEADBEEF to 0x00000010 -> ram_we high only in cycle 3 after the request, ram_addr = 4.
  - Read of the same address -> MIO_ready in cycle 3, Cpu_data4bus = 0xDEADBEEF.
- LED/switch:
  - Write 0x1234ABCD to 0xF0000000 -> led = 0xABCD after the DONE edge.
  - sw = 0x00F0, read 0xF0000000 -> Cpu_data4bus = 0x000000F0.
- Counter:
  - Write 0xFFFFFFFE to 0xF0000004 -> next cycles show 0xFFFFFFFF, then 0x00000000 (wrap).
  - A following read returns the value at the last ACCESS edge.
- Abort and back-to-back:
  - Drop CPU_MIO mid-ACCESS during a RAM write -> no ram_we, no MIO_ready.
  - Two consecutive reads with CPU_MIO held -> MIO_ready pulses exactly WAIT_CYCLES+2 cycles apart.
- Reset mid-write: assert rst_n low during ACCESS of an LED write of 0x5555 -> led stays 0, state IDLE, MIO_ready never asserted.
